pspin_ingress_writer: RTL and testbench
=======================================

# pspin_ingress_writer

Store-and-forward ingress writer that sits between Corundum's RX AXI-Stream path and PsPIN's NIC-inbound AXI write port. It buffers one packet at a time and writes it into a free fixed-size slot of a packet-buffer ring in PsPIN L2 memory with a single AXI INCR burst. It then presents a handler execution request (address, length) to PsPIN. Slots are returned in order by PsPIN through a free pulse.

## Interface
- AXI_DATA_WIDTH, 512, AXI and AXIS data width; the two are always equal.
- AXI_ADDR_WIDTH, 32, PsPIN address width.
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, byte lanes per beat (BYTES).
- AXI_ID_WIDTH, 8, AXI ID width; awid is constant 0.
- LEN_WIDTH, 32, width of the her_len output.
- SLOT_SIZE, 2048, slot bytes; power of two, ≤4096, ≥BYTES.
- NUM_SLOTS, 8, ring depth; power of two.
- MAX_BEATS, SLOT_SIZE/AXI_STRB_WIDTH, staging-buffer depth in beats.
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- s_axis_nic_rx_tdata/tkeep/tvalid/tready/tlast  in/in/in/out/in  AXI_DATA_WIDTH/AXI_STRB_WIDTH/1/1/1  packet stream from NIC. tkeep is contiguous from bit 0.
- m_axi_pspin_ni_awid/awaddr/awlen/awsize/awburst/awvalid/awready  out×6/in  AXI_ID_WIDTH/AXI_ADDR_WIDTH/8/3/2/1/1  write address channel.
- m_axi_pspin_ni_wdata/wstrb/wlast/wvalid/wready  out×4/in  AXI_DATA_WIDTH/AXI_STRB_WIDTH/1/1/1  write data channel.
- m_axi_pspin_ni_bid/bresp/bvalid/bready  in/in/in/out  AXI_ID_WIDTH/2/1/1  write response channel.
- buf_base_addr  in  AXI_ADDR_WIDTH  ring base address, aligned to SLOT_SIZE. Quasi-static; sampled in AW.
- her_valid/her_ready  out/in  1/1  handler request handshake.
- her_addr  out  AXI_ADDR_WIDTH  slot address of the packet.
- her_len  out  LEN_WIDTH  packet length in bytes.
- slot_free  in  1  one-cycle pulse that returns the oldest consumed slot.
- drop_count  out  32  number of oversize packets dropped; wraps.
- write_last_error  out  2  last non-OKAY bresp seen.

## Operation
- Constants: awsize=log2(BYTES), awburst=INCR (01), awid=0.
- State registers: state, beat_cnt, free_cnt (0..NUM_SLOTS), slot_idx (log2 NUM_SLOTS bits, wraps), len_reg, last_keep.
- FILL:
  - tready = (free_cnt≠0).
  - Each accepted beat is written to buf[beat_cnt], then beat_cnt increments.
  - On tlast: len_reg = beat_cnt·BYTES + popcount(tkeep), last_keep = tkeep, go to AW.
  - A beat accepted at beat_cnt==MAX_BEATS-1 without tlast goes to DROP.
- DROP:
  - tready = 1; beats are discarded.
  - On tlast: drop_count++, beat_cnt=0, go to FILL.
- AW:
  - awvalid = 1, awaddr = buf_base_addr + slot_idx·SLOT_SIZE, awlen = beat_cnt-1.
  - On awready go to W. The burst never crosses 4 KB.
- W:
  - wvalid = 1, wdata = buf[rd_ptr], where buf is read asynchronously.
  - wstrb is all-ones, except the final beat, which uses last_keep.
  - wlast = (rd_ptr == beat_cnt-1).
  - On handshake with wlast go to B.
- B:
  - bready = 1.
  - On bvalid with bresp==00 go to HER.
  - On bvalid with bresp≠00: write_last_error = bresp, the slot is not consumed, go to FILL.
- HER:
  - her_valid = 1, her_addr = the AW address, her_len = len_reg.
  - On her_ready: slot_idx++ (wraps NUM_SLOTS-1→0), free_cnt--, beat_cnt=0, go to FILL.
- slot_free increments free_cnt, saturating at NUM_SLOTS.
- slot_free in the same cycle as an HER consume leaves free_cnt unchanged.
- Zero-length packets cannot occur: a tlast beat carries at least one tkeep bit.

## Timing
- Reset values:
  - state=FILL, free_cnt=NUM_SLOTS, slot_idx=0, beat_cnt=0, rd_ptr=0.
  - All valid/ready outputs 0, except tready, which is 1 in FILL with free slots.
  - awaddr, awlen, wdata, wstrb, her_addr, her_len = 0; drop_count=0, write_last_error=0.
- Reset mid-operation abandons any in-flight AXI transaction and returns to reset values.
- Latency:
  - tlast accepted in cycle N → awvalid in N+1.
  - First wvalid is in the cycle after the AW handshake.
  - wvalid stays asserted for beat_cnt consecutive cycles while wready=1.
  - B handshake in cycle M → her_valid in M+1.
  - HER handshake in cycle K → tready in K+1 if free_cnt>0 after the update.
- All valid outputs hold, with data stable, until their ready is seen. No combinational path from any ready input to any valid output.
- The block processes one packet at a time. tready=0 in AW, W, B and HER.

## Test plan
- Single packet, 130 bytes (3 beats, last tkeep=0x3), buf_base_addr=0x1000_0000 → awaddr=0x1000_0000, awlen=2, final wstrb=0x3; her_addr=0x1000_0000, her_len=130.
- Nine 64-byte packets with no slot_free → 8 HERs at base+0..base+0x3800, then tready held at 0. One slot_free pulse → 9th packet written at base+0, showing slot_idx wrap.
- 40-beat packet (MAX_BEATS=32) → no AW issued, drop_count=1. The following 64-byte packet is written normally to slot 0.
- bresp=SLVERR (2'b10) → no her_valid, write_last_error=2'b10. The next packet reuses the same slot address.
- Random awready/wready/her_ready backpressure over 200 packets → data matches the scoreboard, awaddr/awlen/wstrb/wlast and all valid outputs stable while stalled.
- slot_free asserted in the same cycle as the HER handshake with free_cnt=1 → free_cnt stays 1 and tready returns the next cycle. Assert rst mid-W burst → all outputs return to reset values and free_cnt=8.

Source files
------------

// File: rtl/pspin_ingress_writer.sv
// Store-and-forward writer: stages one NIC RX packet, bursts it into the next free
// L2 ring slot over AXI, then hands (address, length) to PsPIN as a handler request.
module pspin_ingress_writer #(
    parameter int AXI_DATA_WIDTH = 512,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
    parameter int AXI_ID_WIDTH   = 8,
    parameter int LEN_WIDTH      = 32,
    parameter int SLOT_SIZE      = 2048,
    parameter int NUM_SLOTS      = 8,
    parameter int MAX_BEATS      = SLOT_SIZE / AXI_STRB_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [AXI_DATA_WIDTH-1:0] s_axis_nic_rx_tdata,
    input  logic [AXI_STRB_WIDTH-1:0] s_axis_nic_rx_tkeep,
    input  logic                      s_axis_nic_rx_tvalid,
    output logic                      s_axis_nic_rx_tready,
    input  logic                      s_axis_nic_rx_tlast,

    output logic [AXI_ID_WIDTH-1:0]   m_axi_pspin_ni_awid,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_pspin_ni_awaddr,
    output logic [7:0]                m_axi_pspin_ni_awlen,
    output logic [2:0]                m_axi_pspin_ni_awsize,
    output logic [1:0]                m_axi_pspin_ni_awburst,
    output logic                      m_axi_pspin_ni_awvalid,
    input  logic                      m_axi_pspin_ni_awready,

    output logic [AXI_DATA_WIDTH-1:0] m_axi_pspin_ni_wdata,
    output logic [AXI_STRB_WIDTH-1:0] m_axi_pspin_ni_wstrb,
    output logic                      m_axi_pspin_ni_wlast,
    output logic                      m_axi_pspin_ni_wvalid,
    input  logic                      m_axi_pspin_ni_wready,

    input  logic [AXI_ID_WIDTH-1:0]   m_axi_pspin_ni_bid,
    input  logic [1:0]                m_axi_pspin_ni_bresp,
    input  logic                      m_axi_pspin_ni_bvalid,
    output logic                      m_axi_pspin_ni_bready,

    input  logic [AXI_ADDR_WIDTH-1:0] buf_base_addr,

    output logic                      her_valid,
    input  logic                      her_ready,
    output logic [AXI_ADDR_WIDTH-1:0] her_addr,
    output logic [LEN_WIDTH-1:0]      her_len,

    input  logic                      slot_free,
    output logic [31:0]               drop_count,
    output logic [1:0]                write_last_error
);

    localparam int CNT_W      = $clog2(MAX_BEATS) + 1;
    localparam int IDX_W      = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int FREE_W     = $clog2(NUM_SLOTS + 1);
    localparam int SLOT_SHIFT = $clog2(SLOT_SIZE);

    typedef enum logic [2:0] {
        ST_FILL,
        ST_DROP,
        ST_AW,
        ST_W,
        ST_B,
        ST_HER
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          beat_cnt;
    logic [CNT_W-1:0]          rd_ptr;
    logic [FREE_W-1:0]         free_cnt;
    logic [SLOT_W-1:0]         slot_idx;
    logic [LEN_WIDTH-1:0]      len_reg;
    logic [AXI_STRB_WIDTH-1:0] last_keep;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_ADDR_WIDTH-1:0] slot_addr;
    logic [AXI_DATA_WIDTH-1:0] buf_mem [MAX_BEATS];
    logic                      rx_fire;
    logic                      at_last_beat;
    logic                      consume;
    logic                      unused_inputs;

    function automatic logic [LEN_WIDTH-1:0] popcount(input logic [AXI_STRB_WIDTH-1:0] v);
        logic [LEN_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < AXI_STRB_WIDTH; i++) c = c + LEN_WIDTH'(v[i]);
        return c;
    endfunction

    assign unused_inputs = ^m_axi_pspin_ni_bid;
    assign rx_fire       = s_axis_nic_rx_tvalid && s_axis_nic_rx_tready;
    assign at_last_beat  = (rd_ptr == beat_cnt - CNT_W'(1));
    assign consume       = (state_q == ST_HER) && her_ready;
    assign slot_addr     = buf_base_addr + (AXI_ADDR_WIDTH'(slot_idx) << SLOT_SHIFT);

    assign m_axi_pspin_ni_awid    = '0;
    assign m_axi_pspin_ni_awsize  = 3'($clog2(AXI_STRB_WIDTH));
    assign m_axi_pspin_ni_awburst = 2'b01;
    assign m_axi_pspin_ni_awaddr  = (state_q == ST_AW) ? slot_addr : '0;
    assign m_axi_pspin_ni_awlen   = (state_q == ST_AW) ? 8'(beat_cnt - CNT_W'(1)) : 8'd0;
    assign m_axi_pspin_ni_wdata   = (state_q == ST_W) ? buf_mem[IDX_W'(rd_ptr)] : '0;
    assign m_axi_pspin_ni_wstrb   = (state_q != ST_W) ? '0 : (at_last_beat ? last_keep : '1);
    assign m_axi_pspin_ni_wlast   = (state_q == ST_W) && at_last_beat;
    assign her_addr               = (state_q == ST_HER) ? addr_q : '0;
    assign her_len                = (state_q == ST_HER) ? len_reg : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_FILL;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d                = state_q;
        s_axis_nic_rx_tready   = 1'b0;
        m_axi_pspin_ni_awvalid = 1'b0;
        m_axi_pspin_ni_wvalid  = 1'b0;
        m_axi_pspin_ni_bready  = 1'b0;
        her_valid              = 1'b0;
        case (state_q)
            ST_FILL: begin
                s_axis_nic_rx_tready = (free_cnt != '0);
                if (s_axis_nic_rx_tvalid && (free_cnt != '0)) begin
                    if (s_axis_nic_rx_tlast)                      state_d = ST_AW;
                    else if (beat_cnt == CNT_W'(MAX_BEATS - 1))   state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                s_axis_nic_rx_tready = 1'b1;
                if (s_axis_nic_rx_tvalid && s_axis_nic_rx_tlast) state_d = ST_FILL;
            end
            ST_AW: begin
                m_axi_pspin_ni_awvalid = 1'b1;
                if (m_axi_pspin_ni_awready) state_d = ST_W;
            end
            ST_W: begin
                m_axi_pspin_ni_wvalid = 1'b1;
                if (m_axi_pspin_ni_wready && at_last_beat) state_d = ST_B;
            end
            ST_B: begin
                m_axi_pspin_ni_bready = 1'b1;
                if (m_axi_pspin_ni_bvalid)
                    state_d = (m_axi_pspin_ni_bresp == 2'b00) ? ST_HER : ST_FILL;
            end
            ST_HER: begin
                her_valid = 1'b1;
                if (her_ready) state_d = ST_FILL;
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Staging buffer has no reset; only beats below beat_cnt are ever read back.
    always_ff @(posedge clk) begin
        if (state_q == ST_FILL && rx_fire) buf_mem[IDX_W'(beat_cnt)] <= s_axis_nic_rx_tdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt         <= '0;
            rd_ptr           <= '0;
            slot_idx         <= '0;
            len_reg          <= '0;
            last_keep        <= '0;
            addr_q           <= '0;
            drop_count       <= '0;
            write_last_error <= '0;
        end else begin
            case (state_q)
                ST_FILL: if (rx_fire) begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                    if (s_axis_nic_rx_tlast) begin
                        len_reg   <= LEN_WIDTH'(beat_cnt) * LEN_WIDTH'(AXI_STRB_WIDTH)
                                     + popcount(s_axis_nic_rx_tkeep);
                        last_keep <= s_axis_nic_rx_tkeep;
                    end
                end
                ST_DROP: if (rx_fire && s_axis_nic_rx_tlast) begin
                    drop_count <= drop_count + 32'd1;
                    beat_cnt   <= '0;
                end
                ST_AW: if (m_axi_pspin_ni_awready) addr_q <= slot_addr;
                ST_W: if (m_axi_pspin_ni_wready) rd_ptr <= at_last_beat ? '0 : rd_ptr + CNT_W'(1);
                ST_B: if (m_axi_pspin_ni_bvalid && m_axi_pspin_ni_bresp != 2'b00) begin
                    write_last_error <= m_axi_pspin_ni_bresp;
                    beat_cnt         <= '0;
                end
                ST_HER: if (her_ready) begin
                    slot_idx <= (slot_idx == SLOT_W'(NUM_SLOTS - 1)) ? '0 : slot_idx + SLOT_W'(1);
                    beat_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // A return pulse coinciding with a consume cancels out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            free_cnt <= FREE_W'(NUM_SLOTS);
        else if (consume && !slot_free)
            free_cnt <= free_cnt - FREE_W'(1);
        else if (!consume && slot_free && free_cnt != FREE_W'(NUM_SLOTS))
            free_cnt <= free_cnt + FREE_W'(1);
    end

endmodule

// File: tb/tb_pspin_ingress_writer.sv
// Directed bench for pspin_ingress_writer: drives packets, plays the AXI slave and
// PsPIN handler side, and compares every output against hand-derived values.
module tb_pspin_ingress_writer;

    localparam int DW  = 512;
    localparam int AW  = 32;
    localparam int SW  = 64;
    localparam int IDW = 8;
    localparam int LW  = 32;
    localparam logic [AW-1:0] BASE = 32'h1000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] tdata;
    logic [SW-1:0] tkeep;
    logic          tvalid, tready, tlast;
    logic [IDW-1:0] awid;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          awvalid, awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wlast, wvalid, wready;
    logic [IDW-1:0] bid;
    logic [1:0]    bresp;
    logic          bvalid, bready;
    logic [AW-1:0] base_addr;
    logic          her_valid, her_ready;
    logic [AW-1:0] her_addr;
    logic [LW-1:0] her_len;
    logic          slot_free;
    logic [31:0]   drop_count;
    logic [1:0]    write_last_error;

    int total = 0;
    int bad   = 0;
    int model_free = 8;
    int model_slot = 0;
    int exp_beats;
    logic [DW-1:0] exp_data [64];
    logic [SW-1:0] exp_keep_last;

    always #5 clk = ~clk;

    pspin_ingress_writer dut (
        .clk                    (clk),
        .rst                    (rst),
        .s_axis_nic_rx_tdata    (tdata),
        .s_axis_nic_rx_tkeep    (tkeep),
        .s_axis_nic_rx_tvalid   (tvalid),
        .s_axis_nic_rx_tready   (tready),
        .s_axis_nic_rx_tlast    (tlast),
        .m_axi_pspin_ni_awid    (awid),
        .m_axi_pspin_ni_awaddr  (awaddr),
        .m_axi_pspin_ni_awlen   (awlen),
        .m_axi_pspin_ni_awsize  (awsize),
        .m_axi_pspin_ni_awburst (awburst),
        .m_axi_pspin_ni_awvalid (awvalid),
        .m_axi_pspin_ni_awready (awready),
        .m_axi_pspin_ni_wdata   (wdata),
        .m_axi_pspin_ni_wstrb   (wstrb),
        .m_axi_pspin_ni_wlast   (wlast),
        .m_axi_pspin_ni_wvalid  (wvalid),
        .m_axi_pspin_ni_wready  (wready),
        .m_axi_pspin_ni_bid     (bid),
        .m_axi_pspin_ni_bresp   (bresp),
        .m_axi_pspin_ni_bvalid  (bvalid),
        .m_axi_pspin_ni_bready  (bready),
        .buf_base_addr          (base_addr),
        .her_valid              (her_valid),
        .her_ready              (her_ready),
        .her_addr               (her_addr),
        .her_len                (her_len),
        .slot_free              (slot_free),
        .drop_count             (drop_count),
        .write_last_error       (write_last_error)
    );

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic sigVal(input int which);
        case (which)
            0:       return tready;
            1:       return awvalid;
            2:       return wvalid;
            3:       return bready;
            default: return her_valid;
        endcase
    endfunction

    // Bounded wait for a DUT output; an expired budget shows up as a failed comparison.
    task automatic waitHigh(input int which, input string tag);
        int guard = 0;
        while (sigVal(which) !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput(tag, DW'(sigVal(which)), DW'(1));
    endtask

    function automatic logic [AW-1:0] slotAddr(input int s);
        return BASE + AW'(s) * 32'h800;
    endfunction

    task automatic checkResetOutputs();
        checkOutput("rst_tready",   DW'(tready),    DW'(1));
        checkOutput("rst_awvalid",  DW'(awvalid),   DW'(0));
        checkOutput("rst_awaddr",   DW'(awaddr),    DW'(0));
        checkOutput("rst_awlen",    DW'(awlen),     DW'(0));
        checkOutput("rst_awsize",   DW'(awsize),    DW'(6));
        checkOutput("rst_awburst",  DW'(awburst),   DW'(1));
        checkOutput("rst_awid",     DW'(awid),      DW'(0));
        checkOutput("rst_wvalid",   DW'(wvalid),    DW'(0));
        checkOutput("rst_wdata",    wdata,          DW'(0));
        checkOutput("rst_wstrb",    DW'(wstrb),     DW'(0));
        checkOutput("rst_wlast",    DW'(wlast),     DW'(0));
        checkOutput("rst_bready",   DW'(bready),    DW'(0));
        checkOutput("rst_her_valid",DW'(her_valid), DW'(0));
        checkOutput("rst_her_addr", DW'(her_addr),  DW'(0));
        checkOutput("rst_her_len",  DW'(her_len),   DW'(0));
        checkOutput("rst_drop_cnt", DW'(drop_count),DW'(0));
        checkOutput("rst_wr_err",   DW'(write_last_error), DW'(0));
    endtask

    task automatic doReset();
        rst = 1'b1;
        tvalid = 0; tlast = 0; tkeep = '0; tdata = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; her_ready = 0; slot_free = 0;
        @(negedge clk);
        checkResetOutputs();
        @(negedge clk);
        rst = 1'b0;
        model_free = 8;
        model_slot = 0;
    endtask

    // Streams one packet of nbytes into the DUT and records the expected beats.
    task automatic applyStimulus(input int nbytes);
        int lastb;
        exp_beats = (nbytes + SW - 1) / SW;
        lastb = nbytes - (exp_beats - 1) * SW;
        exp_keep_last = '0;
        for (int i = 0; i < lastb; i++) exp_keep_last[i] = 1'b1;
        for (int b = 0; b < exp_beats; b++) begin
            exp_data[b] = {$urandom(), $urandom(), $urandom(), $urandom(),
                           $urandom(), $urandom(), $urandom(), $urandom(),
                           $urandom(), $urandom(), $urandom(), $urandom(),
                           $urandom(), $urandom(), $urandom(), $urandom()};
            tdata  = exp_data[b];
            tkeep  = (b == exp_beats - 1) ? exp_keep_last : '1;
            tlast  = (b == exp_beats - 1);
            tvalid = 1'b1;
            waitHigh(0, "tready_beat");
            @(negedge clk);
        end
        tvalid = 0; tlast = 0; tkeep = '0;
    endtask

    task automatic pulseFree();
        slot_free = 1'b1;
        @(negedge clk);
        slot_free = 1'b0;
        if (model_free < 8) model_free++;
    endtask

    // Full packet: stream in, accept AW, drain W, answer B, take the handler request.
    task automatic runPacket(input int nbytes, input logic [1:0] resp, input bit stall, input bit co_free);
        logic [AW-1:0] ea;
        logic [SW-1:0] ek;
        ea = slotAddr(model_slot);
        applyStimulus(nbytes);
        checkOutput("awvalid_latency", DW'(awvalid), DW'(1));
        checkOutput("tready_in_aw",    DW'(tready),  DW'(0));
        if (stall) repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            checkOutput("awvalid_hold", DW'(awvalid), DW'(1));
            checkOutput("awaddr_hold",  DW'(awaddr),  DW'(ea));
            checkOutput("awlen_hold",   DW'(awlen),   DW'(exp_beats - 1));
        end
        checkOutput("awaddr", DW'(awaddr), DW'(ea));
        checkOutput("awlen",  DW'(awlen),  DW'(exp_beats - 1));
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        checkOutput("wvalid_latency", DW'(wvalid), DW'(1));
        for (int b = 0; b < exp_beats; b++) begin
            ek = (b == exp_beats - 1) ? exp_keep_last : '1;
            if (stall) repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                checkOutput("wdata_hold", wdata,      exp_data[b]);
                checkOutput("wstrb_hold", DW'(wstrb), DW'(ek));
                checkOutput("wlast_hold", DW'(wlast), DW'(b == exp_beats - 1));
            end
            checkOutput("wvalid", DW'(wvalid), DW'(1));
            checkOutput("wdata",  wdata,       exp_data[b]);
            checkOutput("wstrb",  DW'(wstrb),  DW'(ek));
            checkOutput("wlast",  DW'(wlast),  DW'(b == exp_beats - 1));
            wready = 1'b1;
            @(negedge clk);
            wready = 1'b0;
        end
        checkOutput("wvalid_after_last", DW'(wvalid), DW'(0));
        waitHigh(3, "bready");
        bvalid = 1'b1; bresp = resp; bid = '0;
        @(negedge clk);
        bvalid = 1'b0; bresp = 2'b00;
        if (resp != 2'b00) begin
            checkOutput("her_valid_on_err", DW'(her_valid),        DW'(0));
            checkOutput("write_last_error", DW'(write_last_error), DW'(resp));
            checkOutput("tready_after_err", DW'(tready),           DW'(model_free != 0));
        end else begin
            checkOutput("her_valid_latency", DW'(her_valid), DW'(1));
            if (stall) repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                checkOutput("her_valid_hold", DW'(her_valid), DW'(1));
                checkOutput("her_addr_hold",  DW'(her_addr),  DW'(ea));
            end
            checkOutput("her_addr", DW'(her_addr), DW'(ea));
            checkOutput("her_len",  DW'(her_len),  DW'(nbytes));
            her_ready = 1'b1;
            slot_free = co_free;
            @(negedge clk);
            her_ready = 1'b0;
            slot_free = 1'b0;
            model_free = model_free - 1 + int'(co_free);
            model_slot = (model_slot + 1) % 8;
            checkOutput("her_valid_after", DW'(her_valid), DW'(0));
            checkOutput("tready_after_her", DW'(tready), DW'(model_free != 0));
        end
    endtask

    initial begin
        bit cf;
        base_addr = BASE;
        bid = '0;
        $display("[TB] start");
        doReset();

        // 130-byte packet: 3 beats, final keep 0x3
        runPacket(130, 2'b00, 1'b0, 1'b0);
        checkOutput("keep_130", DW'(exp_keep_last), DW'(64'h3));
        pulseFree();

        // Fill the whole ring, then show the ninth packet waits for a returned slot
        doReset();
        for (int i = 0; i < 8; i++) runPacket(64, 2'b00, 1'b0, 1'b0);
        tvalid = 1'b1; tlast = 1'b1; tkeep = '1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("tready_ring_full", DW'(tready), DW'(0));
        end
        tvalid = 1'b0; tlast = 1'b0;
        pulseFree();
        runPacket(64, 2'b00, 1'b0, 1'b0);

        // Oversize packet is dropped, following packet lands in slot 0
        doReset();
        applyStimulus(40 * 64);
        checkOutput("drop_no_aw",  DW'(awvalid),    DW'(0));
        checkOutput("drop_count",  DW'(drop_count), DW'(1));
        checkOutput("drop_tready", DW'(tready),     DW'(1));
        repeat (2) begin
            @(negedge clk);
            checkOutput("drop_no_aw_later", DW'(awvalid), DW'(0));
        end
        runPacket(64, 2'b00, 1'b0, 1'b0);

        // Slave error leaves the slot unconsumed; next packet reuses it
        runPacket(64, 2'b10, 1'b0, 1'b0);
        runPacket(64, 2'b00, 1'b0, 1'b0);
        runPacket(2048, 2'b00, 1'b0, 1'b0);
        pulseFree(); pulseFree(); pulseFree();

        // Randomised sizes and backpressure
        for (int p = 0; p < 200; p++) begin
            cf = 1'($urandom_range(0, 1));
            runPacket($urandom_range(1, 2048), 2'b00, 1'b1, cf);
            if (!cf) pulseFree();
        end

        // Slot return coinciding with the last free slot being consumed
        doReset();
        for (int i = 0; i < 7; i++) runPacket(64, 2'b00, 1'b0, 1'b0);
        runPacket(64, 2'b00, 1'b0, 1'b1);
        runPacket(64, 2'b00, 1'b0, 1'b0);

        // Reset in the middle of a W burst
        pulseFree();
        applyStimulus(192);
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        wready = 1'b1;
        @(negedge clk);
        wready = 1'b0;
        checkOutput("mid_w_wvalid", DW'(wvalid), DW'(1));
        rst = 1'b1;
        #1;
        checkResetOutputs();
        @(negedge clk);
        rst = 1'b0;
        model_free = 8;
        model_slot = 0;
        for (int i = 0; i < 8; i++) runPacket(64, 2'b00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
